ne2000_rx_ring: RTL

NE2000_RX_RING -- requirements
Module: ne2000_rx_ring

---
 rtl/ne2000_rx_ring.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ne2000_rx_ring.sv
// NE2000-style receive ring: host register file, packet-to-ring receive FSM with
// 4-byte packet headers, and a remote-DMA read port into the ring RAM.
module ne2000_rx_ring #(
  parameter int         RING_PAGES = 16,
  parameter logic [7:0] BASE_PAGE  = 8'h40,
  parameter int         MAX_FRAME  = 1536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reg_rd,
  input  logic       reg_wr,
  input  logic [4:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       rx_start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_end,
  output logic       rx_ready,
  output logic       irq
);

  localparam int         PW        = $clog2(RING_PAGES);
  localparam int         AW        = PW + 8;
  localparam logic [7:0] PSTOP_RST = BASE_PAGE + 8'(RING_PAGES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_HDR, S_DROP} rx_state_t;

  rx_state_t   state, state_d;
  logic [7:0]  cr, pstart, pstop, bnry, isr, imr, curr;
  logic [15:0] rsar, rbcr, rptr;
  logic [15:0] wptr, wptr_d, len, len_d;
  logic [1:0]  hcnt, hcnt_d;
  logic [7:0]  mem [0:RING_PAGES*256-1];
  logic [7:0]  ram_q, reg_q, rd_mux, isr_d, isr_clr;
  logic        sel_ram;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          set_prx, set_rxe, set_ovw, set_rdc, curr_load;

  function automatic logic [PW-1:0] ram_page(input logic [7:0] p);
    return PW'(p - BASE_PAGE);
  endfunction

  logic       pg0, pg1, dma_rd;
  logic [7:0] wpg_inc, wpg_next, hdr_next, rpg_inc;
  logic [15:0] rptr_next, len_p4;

  assign pg0      = (cr[7:6] == 2'b00);
  assign pg1      = (cr[7:6] == 2'b01);
  assign dma_rd   = reg_rd && reg_addr[4] && (rbcr != 16'd0);
  assign set_rdc  = dma_rd && (rbcr == 16'd1);
  assign wpg_inc  = wptr[15:8] + 8'd1;
  assign wpg_next = (wpg_inc == pstop) ? pstart : wpg_inc;
  // wptr already sits on a fresh page when the last byte closed the previous one.
  assign hdr_next = (wptr[7:0] == 8'h00) ? wptr[15:8] : wpg_next;
  assign len_p4   = len + 16'd4;
  assign rpg_inc  = rptr[15:8] + 8'd1;
  assign rptr_next = (rptr[7:0] != 8'hFF) ? rptr + 16'd1
                   : {((rpg_inc == pstop) ? pstart : rpg_inc), 8'h00};
  assign rx_ready = (state != S_HDR);

  // NOTE: every signal gets a default at the top of a combinational block so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    wptr_d    = wptr;
    len_d     = len;
    hcnt_d    = hcnt;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = 8'h00;
    set_prx   = 1'b0;
    set_rxe   = 1'b0;
    set_ovw   = 1'b0;
    curr_load = 1'b0;
    case (state)
      S_IDLE: if (rx_start) begin
        if (!cr[0]) begin
          wptr_d  = {curr, 8'h04};
          len_d   = 16'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_DROP;
        end
      end
      S_DATA: if (rx_end) begin
        if (len == 16'd0) begin
          set_rxe = 1'b1;
          state_d = S_IDLE;
        end else begin
          hcnt_d  = 2'd0;
          state_d = S_HDR;
        end
      end else if (rx_valid) begin
        if (len == 16'(MAX_FRAME)) begin
          set_rxe = 1'b1;
          state_d = S_DROP;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = {ram_page(wptr[15:8]), wptr[7:0]};
          ram_wdata = rx_data;
          len_d     = len + 16'd1;
          if (wptr[7:0] == 8'hFF) begin
            wptr_d = {wpg_next, 8'h00};
            if (wpg_next == bnry) begin
              set_ovw = 1'b1;
              state_d = S_DROP;
            end
          end else begin
            wptr_d = wptr + 16'd1;
          end
        end
      end
      S_HDR: begin
        ram_we    = 1'b1;
        ram_waddr = {ram_page(curr), 6'd0, hcnt};
        case (hcnt)
          2'd0:    ram_wdata = 8'h01;
          2'd1:    ram_wdata = hdr_next;
          2'd2:    ram_wdata = len_p4[7:0];
          default: ram_wdata = len_p4[15:8];
        endcase
        hcnt_d = hcnt + 2'd1;
        if (hcnt == 2'd3) begin
          curr_load = 1'b1;
          set_prx   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DROP: if (rx_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order between blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      wptr  <= 16'd0;
      len   <= 16'd0;
      hcnt  <= 2'd0;
    end else begin
      state <= state_d;
      wptr  <= wptr_d;
      len   <= len_d;
      hcnt  <= hcnt_d;
    end
  end

  // Clear-on-one host write; hardware sets are OR-ed in afterwards so they win.
  always_comb begin
    isr_clr = (reg_wr && pg0 && reg_addr == 5'h07) ? reg_wdata : 8'h00;
    isr_d   = (isr & ~isr_clr)
            | {1'b0, set_rdc, 1'b0, set_ovw, 1'b0, set_rxe, 1'b0, set_prx};
  end

  always_comb begin
    rd_mux = 8'h00;
    if (reg_addr == 5'h00) begin
      rd_mux = cr;
    end else if (pg0) begin
      case (reg_addr)
        5'h01:   rd_mux = pstart;
        5'h02:   rd_mux = pstop;
        5'h03:   rd_mux = bnry;
        5'h07:   rd_mux = isr;
        5'h08:   rd_mux = rsar[7:0];
        5'h09:   rd_mux = rsar[15:8];
        5'h0A:   rd_mux = rbcr[7:0];
        5'h0B:   rd_mux = rbcr[15:8];
        5'h0F:   rd_mux = imr;
        default: rd_mux = 8'h00;
      endcase
    end else if (pg1 && reg_addr == 5'h07) begin
      rd_mux = curr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cr      <= 8'h21;
      isr     <= 8'h80;
      imr     <= 8'h00;
      pstart  <= BASE_PAGE;
      pstop   <= PSTOP_RST;
      bnry    <= BASE_PAGE;
      curr    <= BASE_PAGE + 8'd1;
      rsar    <= 16'd0;
      rbcr    <= 16'd0;
      rptr    <= 16'd0;
      reg_q   <= 8'h00;
      sel_ram <= 1'b0;
      irq     <= 1'b0;
    end else begin
      isr <= isr_d;
      irq <= |(isr & imr);
      if (dma_rd) begin
        rptr <= rptr_next;
        rbcr <= rbcr - 16'd1;
      end
      if (reg_wr && pg0) begin
        case (reg_addr)
          5'h01:   pstart      <= reg_wdata;
          5'h02:   pstop       <= reg_wdata;
          5'h03:   bnry        <= reg_wdata;
          5'h08:   rsar[7:0]   <= reg_wdata;
          5'h09:   rsar[15:8]  <= reg_wdata;
          5'h0A:   rbcr[7:0]   <= reg_wdata;
          5'h0B:   rbcr[15:8]  <= reg_wdata;
          5'h0F:   imr         <= reg_wdata;
          default: ;
        endcase
      end
      if (reg_wr && reg_addr == 5'h00) begin
        cr <= reg_wdata;
        if (reg_wdata[5:3] == 3'b001) rptr <= rsar;
        if (reg_wdata[5])             rbcr <= 16'd0;
      end
      if (curr_load) begin
        curr <= hdr_next;
      end else if (reg_wr && pg1 && reg_addr == 5'h07 && state == S_IDLE) begin
        curr <= reg_wdata;
      end
      if (reg_rd) begin
        sel_ram <= dma_rd;
        reg_q   <= rd_mux;
      end
    end
  end

  // NOTE: the ring RAM has no reset; its contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (dma_rd) ram_q <= mem[{ram_page(rptr[15:8]), rptr[7:0]}];
  end

  assign reg_rdata = sel_ram ? ram_q : reg_q;

endmodule
